// File: rtl/ddr_tx_serializer.sv
// DDR serial transmitter: a parallel word taken over valid/ready is shifted out
// MSB first, two bits per clk cycle (high phase, then low phase).
module ddr_tx_serializer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             frame
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH / 2 - 1);

   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic             active;
   logic             bit_hi;
   logic             bit_lo;
   logic             load;

   // Ready in the last pair as well, so the next word follows with no gap.
   assign din_ready = rstb & (~active | (cnt == '0));
   assign load      = din_valid & din_ready;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         shreg  <= '0;
         cnt    <= '0;
         active <= 1'b0;
         bit_hi <= 1'b0;
         bit_lo <= 1'b0;
      end else if (load) begin
         bit_hi <= din[WIDTH-1];
         bit_lo <= din[WIDTH-2];
         shreg  <= din << 2;
         cnt    <= CNT_LOAD;
         active <= 1'b1;
      end else if (active && (cnt != '0)) begin
         bit_hi <= shreg[WIDTH-1];
         bit_lo <= shreg[WIDTH-2];
         shreg  <= shreg << 2;
         cnt    <= cnt - 1'b1;
      end else if (active) begin
         active <= 1'b0;
         bit_hi <= 1'b0;
         bit_lo <= 1'b0;
      end
   end

   // Clock level picks the phase bit; registering this again would lose the DDR timing.
   assign dout  = clk ? bit_hi : bit_lo;
   assign frame = active;

endmodule
